memoria_sequencia_n: RTL and testbench

Parametrised memory-game sequence engine: the next-generation game datapath with its own control FSM. It holds a writable sequence store of DEPTH entries, each N_BOTOES wide, and plays the sequence back on the LEDs with programmable on/off times. It then checks the player's presses round by round, with a per-press timeout. It adds a "desafio" mode in which the player extends the sequence by one new entry per round. It sits between the board I/O (buttons, LEDs, 7-segment debug) and the top-level game wrapper, replacing the separate datapath/control pair and the fixed ROMs.

---
 rtl/memoria_sequencia_n.sv | 250 +++++++++++++++++++++++++
 tb/tb_memoria_sequencia_n.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memoria_sequencia_n.sv
// memoria_sequencia_n: memory-game sequence engine with its own control FSM.
// It holds a writable DEPTH x N_BOTOES sequence store and plays rounds 0..limite
// back on the LEDs with programmable on and off times. It then checks the player's
// presses against the store, with a per-press timeout. In desafio mode the player
// appends one new entry per round.
// Ports:
//   clock, reset (async, active-low)   - clock and reset; the store survives reset
//   iniciar, modo_desafio, limite      - start a game; mode and last round are sampled on start
//   botoes                             - synchronised buttons
//   carga, carga_end, carga_dado       - store preload, honoured only when idle
//   leds, pronto                       - LED drive and end-of-game indication
//   acertou, errou, timeout            - result flags, held until the next start
//   db_estado/endereco/sequencia/memoria/jogada - debug visibility
module memoria_sequencia_n #(
    parameter int unsigned N_BOTOES  = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned T_LED_ON  = 500,
    parameter int unsigned T_LED_OFF = 250,
    parameter int unsigned TIMEOUT   = 5000,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                modo_desafio,
    input  logic [AW-1:0]       limite,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                carga,
    input  logic [AW-1:0]       carga_end,
    input  logic [N_BOTOES-1:0] carga_dado,
    output logic [N_BOTOES-1:0] leds,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic [3:0]          db_estado,
    output logic [AW-1:0]       db_endereco,
    output logic [AW-1:0]       db_sequencia,
    output logic [N_BOTOES-1:0] db_memoria,
    output logic [N_BOTOES-1:0] db_jogada
);

    localparam int unsigned T_MAX_P = (T_LED_ON > T_LED_OFF) ? T_LED_ON : T_LED_OFF;
    localparam int unsigned T_MAX   = (TIMEOUT > T_MAX_P) ? TIMEOUT : T_MAX_P;
    localparam int unsigned TW      = $clog2(T_MAX + 1);

    typedef enum logic [3:0] {
        OCIOSO      = 4'd0,
        PREVIEW_ON  = 4'd1,
        PREVIEW_OFF = 4'd2,
        ESPERA      = 4'd3,
        REGISTRA    = 4'd4,
        COMPARA     = 4'd5,
        GRAVA       = 4'd6,
        FIM_RODADA  = 4'd7,
        FIM_ACERTO  = 4'd8,
        FIM_ERRO    = 4'd9,
        FIM_TIMEOUT = 4'd10
    } estado_t;

    estado_t             r_estado,    w_estado_n;
    logic [AW-1:0]       r_endereco,  w_endereco_n;
    logic [AW-1:0]       r_sequencia, w_sequencia_n;
    logic [TW-1:0]       r_timer,     w_timer_n;
    logic                r_modo,      w_modo_n;
    logic [AW-1:0]       r_limite,    w_limite_n;
    logic                r_acertou,   w_acertou_n;
    logic                r_errou,     w_errou_n;
    logic                r_timeout,   w_timeout_n;
    logic [N_BOTOES-1:0] r_jogada;
    logic                r_algum_q;
    logic [N_BOTOES-1:0] r_mem [DEPTH];

    logic [N_BOTOES-1:0] w_mem_rd;
    logic [N_BOTOES-1:0] w_leds;
    logic [AW-1:0]       w_ultimo;
    logic                w_press;
    logic                w_inicio;
    logic                w_grava;
    logic                w_carga_ok;

    // A press is the idle-to-any-button transition; a held button never re-triggers
    assign w_press  = (|botoes) & ~r_algum_q;
    assign w_mem_rd = r_mem[r_endereco];
    // Last previewed index: desafio rounds preview only the entries before the new one
    assign w_ultimo = r_modo ? (r_sequencia - 1'b1) : r_sequencia;

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado    <= OCIOSO;
            r_endereco  <= '0;
            r_sequencia <= '0;
            r_timer     <= '0;
            r_modo      <= 1'b0;
            r_limite    <= '0;
            r_acertou   <= 1'b0;
            r_errou     <= 1'b0;
            r_timeout   <= 1'b0;
            r_jogada    <= '0;
            r_algum_q   <= 1'b0;
        end else begin
            r_estado    <= w_estado_n;
            r_endereco  <= w_endereco_n;
            r_sequencia <= w_sequencia_n;
            r_timer     <= w_timer_n;
            r_modo      <= w_modo_n;
            r_limite    <= w_limite_n;
            r_acertou   <= w_acertou_n;
            r_errou     <= w_errou_n;
            r_timeout   <= w_timeout_n;
            r_algum_q   <= |botoes;
            if (r_estado == ESPERA && w_press) begin
                r_jogada <= botoes;
            end
        end
    end

    // Sequence store: no reset so contents survive a mid-game reset
    always_ff @(posedge clock) begin
        if (w_grava) begin
            r_mem[r_endereco] <= r_jogada;
        end else if (w_carga_ok) begin
            r_mem[carga_end] <= carga_dado;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_estado_n    = r_estado;
        w_endereco_n  = r_endereco;
        w_sequencia_n = r_sequencia;
        w_timer_n     = r_timer;
        w_modo_n      = r_modo;
        w_limite_n    = r_limite;
        w_acertou_n   = r_acertou;
        w_errou_n     = r_errou;
        w_timeout_n   = r_timeout;
        w_leds        = '0;
        w_inicio      = 1'b0;
        w_grava       = 1'b0;
        w_carga_ok    = 1'b0;

        unique case (r_estado)
            OCIOSO: begin
                w_carga_ok = carga;
                w_inicio   = iniciar;
            end
            PREVIEW_ON: begin
                w_leds = w_mem_rd;
                if (r_timer == TW'(T_LED_ON - 1)) begin
                    w_timer_n  = '0;
                    w_estado_n = PREVIEW_OFF;
                end else begin
                    w_timer_n = r_timer + 1'b1;
                end
            end
            PREVIEW_OFF: begin
                if (r_timer == TW'(T_LED_OFF - 1)) begin
                    w_timer_n = '0;
                    if (r_endereco == w_ultimo) begin
                        w_endereco_n = '0;
                        w_estado_n   = ESPERA;
                    end else begin
                        w_endereco_n = r_endereco + 1'b1;
                        w_estado_n   = PREVIEW_ON;
                    end
                end else begin
                    w_timer_n = r_timer + 1'b1;
                end
            end
            ESPERA: begin
                w_leds = botoes;
                // A press on the last timer cycle still counts
                if (w_press) begin
                    w_estado_n = REGISTRA;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_timeout_n = 1'b1;
                    w_estado_n  = FIM_TIMEOUT;
                end else begin
                    w_timer_n = r_timer + 1'b1;
                end
            end
            REGISTRA: begin
                w_estado_n = COMPARA;
            end
            COMPARA: begin
                if (r_modo && (r_endereco == r_sequencia)) begin
                    w_estado_n = GRAVA;
                end else if (r_jogada != w_mem_rd) begin
                    w_errou_n  = 1'b1;
                    w_estado_n = FIM_ERRO;
                end else if (r_endereco == r_sequencia) begin
                    w_estado_n = FIM_RODADA;
                end else begin
                    w_endereco_n = r_endereco + 1'b1;
                    w_timer_n    = '0;
                    w_estado_n   = ESPERA;
                end
            end
            GRAVA: begin
                w_grava    = 1'b1;
                w_estado_n = FIM_RODADA;
            end
            FIM_RODADA: begin
                if (r_sequencia == r_limite) begin
                    w_acertou_n = 1'b1;
                    w_estado_n  = FIM_ACERTO;
                end else begin
                    w_sequencia_n = r_sequencia + 1'b1;
                    w_endereco_n  = '0;
                    w_timer_n     = '0;
                    w_estado_n    = PREVIEW_ON;
                end
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                w_inicio = iniciar;
            end
            default: begin
                w_estado_n = OCIOSO;
            end
        endcase

        // Game start: desafio round 0 has nothing to preview
        if (w_inicio) begin
            w_endereco_n  = '0;
            w_sequencia_n = '0;
            w_timer_n     = '0;
            w_acertou_n   = 1'b0;
            w_errou_n     = 1'b0;
            w_timeout_n   = 1'b0;
            w_modo_n      = modo_desafio;
            w_limite_n    = limite;
            w_estado_n    = modo_desafio ? ESPERA : PREVIEW_ON;
        end
    end

    assign leds         = w_leds;
    assign pronto       = (r_estado == FIM_ACERTO) || (r_estado == FIM_ERRO) ||
                          (r_estado == FIM_TIMEOUT);
    assign acertou      = r_acertou;
    assign errou        = r_errou;
    assign timeout      = r_timeout;
    assign db_estado    = r_estado;
    assign db_endereco  = r_endereco;
    assign db_sequencia = r_sequencia;
    assign db_memoria   = w_mem_rd;
    assign db_jogada    = r_jogada;

endmodule

// File: tb/tb_memoria_sequencia_n.sv
// Testbench for memoria_sequencia_n: a table of scripted games, hand-written timing
// corner cases and randomized games. A player model drives the buttons from the
// bench's own copy of the store.
module tb_memoria_sequencia_n;
    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned T_ON  = 3;
    localparam int unsigned T_OFF = 2;
    localparam int unsigned TO    = 20;

    logic          clock = 1'b0;
    logic          reset;
    logic          iniciar;
    logic          modo_desafio;
    logic [AW-1:0] limite;
    logic [N-1:0]  botoes;
    logic          carga;
    logic [AW-1:0] carga_end;
    logic [N-1:0]  carga_dado;
    logic [N-1:0]  leds;
    logic          pronto, acertou, errou, timeout;
    logic [3:0]    db_estado;
    logic [AW-1:0] db_endereco, db_sequencia;
    logic [N-1:0]  db_memoria, db_jogada;

    memoria_sequencia_n #(
        .N_BOTOES(N), .DEPTH(DEPTH), .T_LED_ON(T_ON), .T_LED_OFF(T_OFF), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .modo_desafio(modo_desafio),
        .limite(limite), .botoes(botoes), .carga(carga), .carga_end(carga_end),
        .carga_dado(carga_dado), .leds(leds), .pronto(pronto), .acertou(acertou),
        .errou(errou), .timeout(timeout), .db_estado(db_estado), .db_endereco(db_endereco),
        .db_sequencia(db_sequencia), .db_memoria(db_memoria), .db_jogada(db_jogada)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    logic [N-1:0] m_store [DEPTH];
    logic [N-1:0] m_jog;

    typedef struct {
        bit           modo;
        int           lim;
        int           err_r;
        int           err_i;
        logic [N-1:0] err_v;
        int           to_r;
        logic [15:0]  dv;
        int           exp_st;
        int           exp_seq;
        int           exp_end;
        logic [N-1:0] exp_jog;
        logic [N-1:0] exp_mem;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_state(input logic [3:0] st, input int budget, input string name);
        for (int c = 0; c < budget && db_estado != st; c++) tick();
        check(name, 32'(db_estado), 32'(st));
    endtask

    task automatic wait_pronto(input int budget);
        for (int c = 0; c < budget && !pronto; c++) tick();
        check("pronto", 32'(pronto), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        m_jog = '0;
    endtask

    // Preload: pattern 1,2,4,8,... or random nonzero values
    task automatic preload(input bit rnd);
        for (int a = 0; a < int'(DEPTH); a++) begin
            logic [N-1:0] v;
            v = rnd ? N'($urandom_range(1, 15)) : N'(1 << (a % 4));
            m_store[a] = v;
            carga = 1'b1; carga_end = AW'(a); carga_dado = v;
            tick();
        end
        carga = 1'b0;
    endtask

    // Plays one game as the player; err_v==0 picks a random wrong value at press time
    task automatic play_game(input bit modo, input int lim, input int err_r, input int err_i,
                             input logic [N-1:0] err_v, input int to_r, input logic [15:0] dv,
                             input bit use_dv, input bit cw, input logic [N-1:0] cw_dat,
                             output int exp_st, output int exp_seq, output int exp_end);
        bit done;
        bit is_err;
        int last, n_prev, n_on;
        logic [N-1:0] prev, v, good;
        logic [N-1:0] runs [$];
        done = 1'b0;
        exp_st = 0; exp_seq = 0; exp_end = 0;
        iniciar = 1'b1; modo_desafio = modo; limite = AW'(lim);
        if (cw) begin
            carga = 1'b1; carga_end = '0; carga_dado = cw_dat; m_store[0] = cw_dat;
        end
        tick();
        iniciar = 1'b0; carga = 1'b0;
        check("flags_clear", 32'({acertou, errou, timeout}), 32'd0);
        for (int r = 0; r <= lim && !done; r++) begin
            if (!(modo && r == 0)) begin
                last = modo ? r - 1 : r;
                runs.delete();
                prev = '0; n_prev = 0; n_on = 0;
                for (int c = 0; c < 400 && db_estado != 4'd3; c++) begin
                    if (db_estado == 4'd1 || db_estado == 4'd2) n_prev++;
                    if (leds != '0) n_on++;
                    if (leds != '0 && prev == '0) runs.push_back(leds);
                    prev = leds;
                    tick();
                end
                check("reach_espera", 32'(db_estado), 32'd3);
                check("preview_cycles", 32'(n_prev), 32'((last + 1) * int'(T_ON + T_OFF)));
                check("preview_on_cycles", 32'(n_on), 32'((last + 1) * int'(T_ON)));
                check("preview_count", 32'(runs.size()), 32'(last + 1));
                for (int i = 0; i < runs.size() && i <= last; i++)
                    check("preview_val", 32'(runs[i]), 32'(m_store[i]));
            end else begin
                wait_state(4'd3, 10, "reach_espera");
            end
            if (db_estado != 4'd3) done = 1'b1;
            for (int i = 0; i <= r && !done; i++) begin
                if (i > 0) begin
                    wait_state(4'd3, 20, "back_to_espera");
                    if (db_estado != 4'd3) begin done = 1'b1; break; end
                end
                if (r == to_r && i == 0) begin
                    wait_pronto(TO + 10);
                    exp_st = 10; exp_seq = r; exp_end = 0; done = 1'b1;
                end else begin
                    is_err = 1'b0;
                    if (modo && i == r) begin
                        v = use_dv ? dv[4*r +: 4] : N'($urandom_range(1, 15));
                        m_store[r] = v;
                    end else if (r == err_r && i == err_i) begin
                        good = m_store[i];
                        v = err_v;
                        for (int k = 0; k < 64 && (v == '0 || v == good); k++)
                            v = N'($urandom_range(1, 15));
                        is_err = 1'b1;
                    end else begin
                        v = m_store[i];
                    end
                    botoes = v;
                    tick();
                    botoes = '0;
                    m_jog = v;
                    if (is_err) begin
                        exp_st = 9; exp_seq = r; exp_end = i; done = 1'b1;
                    end
                end
            end
            if (!done && r == lim) begin
                exp_st = 8; exp_seq = lim; exp_end = lim; done = 1'b1;
            end
        end
        wait_pronto(40);
    endtask

    task automatic verify_end(input string tag, input int st, input int sq, input int en,
                              input logic [N-1:0] jog, input logic [N-1:0] mem);
        logic [2:0] fl;
        fl = (st == 8) ? 3'b100 : (st == 9) ? 3'b010 : 3'b001;
        check({tag, "_estado"},    32'(db_estado),    32'(st));
        check({tag, "_sequencia"}, 32'(db_sequencia), 32'(sq));
        check({tag, "_endereco"},  32'(db_endereco),  32'(en));
        check({tag, "_jogada"},    32'(db_jogada),    32'(jog));
        check({tag, "_memoria"},   32'(db_memoria),   32'(mem));
        check({tag, "_flags"},     32'({acertou, errou, timeout}), 32'(fl));
        check({tag, "_leds"},      32'(leds),         32'd0);
    endtask

    initial begin
        vec_t tbl [7];
        int st, sq, en, cnt;
        reset = 1'b0; iniciar = 1'b0; modo_desafio = 1'b0; limite = '0;
        botoes = '0; carga = 1'b0; carga_end = '0; carga_dado = '0; m_jog = '0;
        tick();
        tick();
        // Reset values
        check("rst_leds",   32'(leds),         32'd0);
        check("rst_pronto", 32'(pronto),       32'd0);
        check("rst_flags",  32'({acertou, errou, timeout}), 32'd0);
        check("rst_estado", 32'(db_estado),    32'd0);
        check("rst_end",    32'(db_endereco),  32'd0);
        check("rst_seq",    32'(db_sequencia), 32'd0);
        check("rst_jog",    32'(db_jogada),    32'd0);
        reset = 1'b1;
        tick();

        // Scripted games on the 1,2,4,8 store
        tbl[0] = '{0, 2, -1, 0, 4'h0, -1, 16'h0,    8, 2, 2, 4'h4, 4'h4};
        tbl[1] = '{0, 2,  1, 1, 4'h4, -1, 16'h0,    9, 1, 1, 4'h4, 4'h2};
        tbl[2] = '{0, 3, -1, 0, 4'h0,  2, 16'h0,   10, 2, 0, 4'h2, 4'h1};
        tbl[3] = '{1, 1, -1, 0, 4'h0, -1, 16'h0082, 8, 1, 1, 4'h8, 4'h8};
        tbl[4] = '{0, 0, -1, 0, 4'h0,  0, 16'h0,   10, 0, 0, 4'h0, 4'h1};
        tbl[5] = '{1, 3,  2, 1, 4'h1, -1, 16'h0421, 9, 2, 1, 4'h1, 4'h2};
        tbl[6] = '{0, 15, -1, 0, 4'h0, -1, 16'h0,   8, 15, 15, 4'h8, 4'h8};
        for (int t = 0; t < 7; t++) begin
            do_reset();
            preload(1'b0);
            play_game(tbl[t].modo, tbl[t].lim, tbl[t].err_r, tbl[t].err_i, tbl[t].err_v,
                      tbl[t].to_r, tbl[t].dv, 1'b1, 1'b0, '0, st, sq, en);
            verify_end($sformatf("vec%0d", t), tbl[t].exp_st, tbl[t].exp_seq,
                       tbl[t].exp_end, tbl[t].exp_jog, tbl[t].exp_mem);
        end

        // Timeout exactly TIMEOUT cycles after entering ESPERA
        do_reset();
        preload(1'b0);
        iniciar = 1'b1; modo_desafio = 1'b0; limite = '0;
        tick();
        iniciar = 1'b0;
        wait_state(4'd3, 50, "to_espera");
        cnt = 0;
        while (db_estado == 4'd3 && cnt < int'(TO) + 5) begin cnt++; tick(); end
        check("timeout_cycles", 32'(cnt), 32'(TO));
        check("timeout_state",  32'(db_estado), 32'd10);
        check("timeout_flag",   32'(timeout), 32'd1);
        check("timeout_pronto", 32'(pronto), 32'd1);

        // Press on the last timer cycle is accepted; press-to-verdict latency
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        wait_state(4'd3, 50, "late_espera");
        repeat (TO - 1) tick();
        botoes = m_store[0];
        tick();
        botoes = '0;
        m_jog = m_store[0];
        check("late_registra", 32'(db_estado), 32'd4);
        tick();
        check("late_compara", 32'(db_estado), 32'd5);
        tick();
        check("late_fim_rodada", 32'(db_estado), 32'd7);
        tick();
        check("late_acerto", 32'(db_estado), 32'd8);
        check("late_acertou", 32'(acertou), 32'd1);

        // Button held from preview into ESPERA does not count
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        botoes = 4'h6;
        wait_state(4'd3, 50, "held_espera");
        for (int k = 0; k < 5; k++) begin
            tick();
            check("held_state", 32'(db_estado), 32'd3);
            check("held_leds",  32'(leds), 32'h6);
        end
        check("held_jogada", 32'(db_jogada), 32'(m_jog));
        botoes = '0;
        tick();
        check("release_state", 32'(db_estado), 32'd3);
        botoes = m_store[0];
        tick();
        botoes = '0;
        m_jog = m_store[0];
        wait_pronto(20);
        verify_end("held", 8, 0, 0, m_store[0], m_store[0]);

        // Reset during PREVIEW_ON; carga outside OCIOSO is ignored
        iniciar = 1'b1; limite = AW'(2);
        tick();
        iniciar = 1'b0;
        wait_state(4'd1, 10, "rstmid_preview");
        carga = 1'b1; carga_end = AW'(1); carga_dado = 4'hF;
        tick();
        carga = 1'b0;
        wait_state(4'd1, 10, "rstmid_preview2");
        reset = 1'b0;
        #1;
        check("rstmid_leds",   32'(leds),         32'd0);
        check("rstmid_pronto", 32'(pronto),       32'd0);
        check("rstmid_flags",  32'({acertou, errou, timeout}), 32'd0);
        check("rstmid_estado", 32'(db_estado),    32'd0);
        check("rstmid_end",    32'(db_endereco),  32'd0);
        check("rstmid_seq",    32'(db_sequencia), 32'd0);
        check("rstmid_jog",    32'(db_jogada),    32'd0);
        tick();
        reset = 1'b1;
        tick();
        m_jog = '0;
        play_game(1'b0, 2, -1, 0, '0, -1, '0, 1'b0, 1'b0, '0, st, sq, en);
        verify_end("rstmid_game", 8, 2, 2, m_store[2], m_store[2]);

        // Randomized games against the player model
        for (int g = 0; g < 14; g++) begin
            bit md, cw;
            int lim, k, er, ei, tr;
            cw = 1'b0;
            if (g == 0 || $urandom_range(0, 2) == 0) begin
                do_reset();
                preload(1'b1);
                cw = 1'b1;
            end
            md  = 1'($urandom_range(0, 1));
            lim = $urandom_range(0, 3);
            k   = $urandom_range(0, 5);
            er = -1; ei = 0; tr = -1;
            if (k == 0) begin
                tr = $urandom_range(0, lim);
            end else if (k <= 2) begin
                er = $urandom_range(0, lim);
                if (md && er == 0) er = -1;
                else ei = $urandom_range(0, md ? er - 1 : er);
            end
            play_game(md, lim, er, ei, '0, tr, '0, 1'b0, cw,
                      N'($urandom_range(1, 15)), st, sq, en);
            verify_end($sformatf("rnd%0d", g), st, sq, en, m_jog, m_store[en]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
